// File: rtl/rush3d_avalon_pkg.sv
// Shared types and f2h SDRAM port widths for the Avalon burst responder.
// Defaults here match the HPS f2h SDRAM ports.
package rush3d_avalon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_BURST,
      READ_BURST
   } state_t;

   localparam int F2H_ADDR_WIDTH   = 29;
   localparam int F2H_DATA_WIDTH   = 64;
   localparam int F2H_BURST_WIDTH  = 8;
   localparam int MAX_READ_LATENCY = 8;

endpackage

// File: rtl/byte_ram.sv
// Simple dual-port RAM with byte enables, write-first bypass and a
// registered read port that holds its value when not reading.
module byte_ram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [DATA_W-1:0]   q
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_word;

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Same-cycle write to the read address is forwarded lane by lane.
   always_comb begin
      rd_word = mem[raddr];
      for (int b = 0; b < NB; b++) begin
         if (we && be[b] && (waddr == raddr)) begin
            rd_word[b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= '0;
      else if (re) q <= rd_word;
   end

endmodule

// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst responder backed by on-chip RAM, one burst at a time,
// with stall injection to exercise master backpressure.
module avalon_burst_responder
   import rush3d_avalon_pkg::*;
#(
   parameter int ADDR_WIDTH     = F2H_ADDR_WIDTH,
   parameter int DATA_WIDTH     = F2H_DATA_WIDTH,
   parameter int BURST_WIDTH    = F2H_BURST_WIDTH,
   parameter int MEM_DEPTH_LOG2 = 12,
   parameter int READ_LATENCY   = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [BURST_WIDTH-1:0]  burstcount,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   output logic                    waitrequest,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   input  logic                    stall,
   output logic                    busy,
   output logic                    protocol_error
);

   localparam int MW = MEM_DEPTH_LOG2;

   state_t state, state_n;
   logic                   first_q;
   logic [MW-1:0]          base, wr_off, rd_off;
   logic [MW-1:0]          ram_waddr, ram_raddr;
   logic [BURST_WIDTH-1:0] wr_left, issue_left, rcv_left;
   logic                   ram_we, ram_re, ram_vld;
   logic                   err_set, ld_wr, ld_rd, wr_step;
   logic                   accept, unused_addr;
   logic [DATA_WIDTH-1:0]  ram_q;

   assign unused_addr = ^address[ADDR_WIDTH-1:MW];

   assign waitrequest = stall | reset
                      | (state == READ_BURST)
                      | ((state == IDLE) & first_q);

   assign accept    = (read | write) & ~waitrequest;
   assign ram_raddr = base + rd_off;

   always_comb begin
      state_n   = state;
      ram_we    = 1'b0;
      ram_waddr = base + wr_off;
      ram_re    = 1'b0;
      err_set   = 1'b0;
      ld_wr     = 1'b0;
      ld_rd     = 1'b0;
      wr_step   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept && write) begin
               err_set = read || (burstcount == '0);
               if (burstcount != '0) begin
                  ram_we    = 1'b1;
                  ram_waddr = address[MW-1:0];
                  ld_wr     = 1'b1;
                  if (burstcount != BURST_WIDTH'(1)) state_n = WRITE_BURST;
               end
            end else if (accept && read) begin
               if (burstcount == '0) begin
                  err_set = 1'b1;
               end else begin
                  ld_rd   = 1'b1;
                  state_n = READ_BURST;
               end
            end
         end
         WRITE_BURST: begin
            err_set = read;
            if (write && !stall) begin
               ram_we  = 1'b1;
               wr_step = 1'b1;
               if (wr_left == BURST_WIDTH'(1)) state_n = IDLE;
            end
         end
         READ_BURST: begin
            ram_re = (issue_left != '0);
            if (readdatavalid && rcv_left == BURST_WIDTH'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         first_q        <= 1'b1;
         busy           <= 1'b0;
         protocol_error <= 1'b0;
         ram_vld        <= 1'b0;
         base           <= '0;
         wr_off         <= '0;
         rd_off         <= '0;
         wr_left        <= '0;
         issue_left     <= '0;
         rcv_left       <= '0;
      end else begin
         first_q <= 1'b0;
         busy    <= (state_n != IDLE);
         ram_vld <= ram_re;
         if (err_set) protocol_error <= 1'b1;
         if (ld_wr) begin
            base    <= address[MW-1:0];
            wr_off  <= MW'(1);
            wr_left <= burstcount - 1'b1;
         end
         if (wr_step) begin
            wr_off  <= wr_off + 1'b1;
            wr_left <= wr_left - 1'b1;
         end
         if (ld_rd) begin
            base       <= address[MW-1:0];
            rd_off     <= '0;
            issue_left <= burstcount;
            rcv_left   <= burstcount;
         end
         if (ram_re) begin
            rd_off     <= rd_off + 1'b1;
            issue_left <= issue_left - 1'b1;
         end
         if (readdatavalid && state == READ_BURST) rcv_left <= rcv_left - 1'b1;
      end
   end

   byte_ram #(
      .ADDR_W (MW),
      .DATA_W (DATA_WIDTH)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (writedata),
      .be    (byteenable),
      .re    (ram_re),
      .raddr (ram_raddr),
      .q     (ram_q)
   );

   // Extra return stages only advance data on valid, so readdata holds.
   if (READ_LATENCY == 1) begin : g_lat1
      assign readdatavalid = ram_vld;
      assign readdata      = ram_q;
   end else begin : g_pipe
      localparam int S = READ_LATENCY - 1;
      logic [S-1:0]          pv;
      logic [DATA_WIDTH-1:0] pd [S];

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            pv <= '0;
            for (int k = 0; k < S; k++) pd[k] <= '0;
         end else begin
            pv[0] <= ram_vld;
            if (ram_vld) pd[0] <= ram_q;
            for (int k = 1; k < S; k++) begin
               pv[k] <= pv[k-1];
               if (pv[k-1]) pd[k] <= pd[k-1];
            end
         end
      end

      assign readdatavalid = pv[S-1];
      assign readdata      = pd[S-1];
   end

endmodule

// File: tb/tb_avalon_burst_responder.sv
// Self-checking bench for avalon_burst_responder: a scoreboard of read
// beats with their expected cycles, a byte-lane vector table, corner cases.
module tb_avalon_burst_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [28:0] address = '0;
   logic [7:0]  burstcount = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [63:0] writedata = '0;
   logic [7:0]  byteenable = '0;
   logic        waitrequest;
   logic [63:0] readdata;
   logic        readdatavalid;
   logic        stall = 1'b0;
   logic        busy;
   logic        protocol_error;

   avalon_burst_responder dut (
      .clock          (clock),
      .reset          (reset),
      .address        (address),
      .burstcount     (burstcount),
      .read           (read),
      .write          (write),
      .writedata      (writedata),
      .byteenable     (byteenable),
      .waitrequest    (waitrequest),
      .readdata       (readdata),
      .readdatavalid  (readdatavalid),
      .stall          (stall),
      .busy           (busy),
      .protocol_error (protocol_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clock) cyc++;

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      logic [28:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin : mon
      exp_t e;
      if (readdatavalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdv: got beat %h at cycle %0d, required none", readdata, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", readdata, e.data);
            chk("rd_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic wait_accept(input string name);
      int n;
      n = 0;
      @(negedge clock);
      while (waitrequest && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got waitrequest stuck high, required acceptance", name);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic wr_beat(input logic [28:0] a, input logic [7:0] bc,
                          input logic [63:0] d, input logic [7:0] be);
      address    = a;
      burstcount = bc;
      writedata  = d;
      byteenable = be;
      write      = 1'b1;
      wait_accept("wr");
      write = 1'b0;
   endtask

   task automatic rd_cmd(input logic [28:0] a, input logic [7:0] bc, output int t0);
      address    = a;
      burstcount = bc;
      read       = 1'b1;
      wait_accept("rd");
      read = 1'b0;
      t0   = cyc;
   endtask

   task automatic push(input logic [63:0] d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, required end of test");
      $fatal(1);
   end

   initial begin
      int t0, rel, idx, stalled, c;
      logic acc;

      vecs[0] = '{29'h20,   64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA};
      vecs[1] = '{29'h20,   64'h5555_5555_5555_5555, 8'h0F, 64'hAAAA_AAAA_5555_5555};
      vecs[2] = '{29'h21,   64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};
      vecs[3] = '{29'h21,   64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 64'hFF23_4567_89AB_CDEF};
      vecs[4] = '{29'h21,   64'h0000_0000_0000_0000, 8'h01, 64'hFF23_4567_89AB_CD00};
      vecs[5] = '{29'h1022, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
      vecs[6] = '{29'h22,   64'h1234_1234_1234_1234, 8'h00, 64'hDEAD_BEEF_CAFE_F00D};

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_waitreq", 64'(waitrequest), 64'd1);
      chk("rst_rdv", 64'(readdatavalid), 64'd0);
      chk("rst_readdata", readdata, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_perr", 64'(protocol_error), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("first_cycle_waitreq", 64'(waitrequest), 64'd1);
      @(negedge clock);
      chk("idle_waitreq", 64'(waitrequest), 64'd0);
      @(posedge clock);
      #1;

      // write burst of 4 at 0x10, read it back
      for (int i = 0; i < 4; i++) begin
         wr_beat(29'h10, 8'd4, 64'h1111_1111_1111_1111 * 64'(i + 1), 8'hFF);
      end
      rd_cmd(29'h10, 8'd4, t0);
      for (int i = 0; i < 4; i++) push(64'h1111_1111_1111_1111 * 64'(i + 1), t0 + 2 + i);
      @(negedge clock);
      chk("busy_in_read", 64'(busy), 64'd1);
      chk("waitreq_in_read", 64'(waitrequest), 64'd1);
      drain();
      chk("perr_clean", 64'(protocol_error), 64'd0);

      // byte-lane table
      for (int v = 0; v < 7; v++) begin
         wr_beat(vecs[v].addr, 8'd1, vecs[v].wdata, vecs[v].be);
         rd_cmd(vecs[v].addr, 8'd1, t0);
         push(vecs[v].exp, t0 + 2);
         drain();
      end

      // wrap past the top of the RAM
      for (int i = 0; i < 3; i++) wr_beat(29'hFFF, 8'd3, 64'(i + 1), 8'hFF);
      rd_cmd(29'h000, 8'd2, t0);
      push(64'd2, t0 + 2);
      push(64'd3, t0 + 3);
      drain();
      rd_cmd(29'hFFF, 8'd1, t0);
      push(64'd1, t0 + 2);
      drain();
      rd_cmd(29'h1FFF, 8'd1, t0);
      push(64'd1, t0 + 2);
      drain();

      // stall held 5 cycles inside a write burst of 8
      address    = 29'h100;
      burstcount = 8'd8;
      byteenable = 8'hFF;
      write      = 1'b1;
      idx        = 0;
      stalled    = 0;
      c          = 0;
      while (idx < 8 && c < 40) begin
         writedata = 64'hB000 + 64'(idx);
         stall     = (c >= 3 && c < 8);
         @(negedge clock);
         chk("stall_waitreq", 64'(waitrequest), 64'(stall));
         acc = !waitrequest;
         if (waitrequest) stalled++;
         @(posedge clock);
         #1;
         if (acc) idx++;
         c++;
      end
      write = 1'b0;
      stall = 1'b0;
      chk("stall_beats", 64'(idx), 64'd8);
      chk("stall_cycles", 64'(stalled), 64'd5);
      @(negedge clock);
      chk("busy_after_wr", 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      rd_cmd(29'h100, 8'd8, t0);
      for (int i = 0; i < 8; i++) push(64'hB000 + 64'(i), t0 + 2 + i);
      drain();

      // zero burstcount read: error, no data, never busy
      chk("perr_before_bc0", 64'(protocol_error), 64'd0);
      rd_cmd(29'h10, 8'd0, t0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("bc0_busy", 64'(busy), 64'd0);
      end
      chk("bc0_perr", 64'(protocol_error), 64'd1);
      @(posedge clock);
      #1;

      // read and write together in IDLE: write wins, read dropped
      read = 1'b1;
      wr_beat(29'h30, 8'd1, 64'hC0FF_EE00_C0FF_EE00, 8'hFF);
      read = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      rd_cmd(29'h30, 8'd1, t0);
      push(64'hC0FF_EE00_C0FF_EE00, t0 + 2);
      drain();
      chk("rw_perr", 64'(protocol_error), 64'd1);

      // reset the cycle after a 16-beat read is accepted
      rd_cmd(29'h100, 8'd16, t0);
      reset = 1'b1;
      #1;
      chk("rst_rdv_now", 64'(readdatavalid), 64'd0);
      repeat (3) begin
         @(negedge clock);
         chk("rst_rdv_hold", 64'(readdatavalid), 64'd0);
      end
      chk("rst_perr_clear", 64'(protocol_error), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      rel   = cyc;
      rd_cmd(29'h10, 8'd4, t0);
      chk("first_accept_cycle", 64'(t0), 64'(rel + 2));
      for (int i = 0; i < 4; i++) push(64'h1111_1111_1111_1111 * 64'(i + 1), t0 + 2 + i);
      drain();
      repeat (20) @(posedge clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
Avalon-MM burst slave (responder) with an on-chip RAM behind it. It is the far end of the sdram0/sdram1 master interfaces driven by framebuffer_read and framebuffer_write. It stands in for the HPS f2h SDRAM port in block-level and top-level simulation, and doubles as an FPGA-side scratch buffer. It serves one burst at a time and supports programmable stall injection to exercise master backpressure handling.

Parameters:
ADDR_WIDTH, 29, word (beat) address width; matches the f2h SDRAM ports.
DATA_WIDTH, 64, beat width in bits; byteenable width is DATA_WIDTH/8.
BURST_WIDTH, 8, burstcount width; maximum burst is 2^(BURST_WIDTH-1) beats.
MEM_DEPTH_LOG2, 12, RAM depth in beats (4096).
READ_LATENCY, 2, cycles from read-command acceptance to the first readdatavalid; legal range 1..8.

Ports:
clock  in  1  system clock (clock_50 domain)
reset  in  1  asynchronous, active-high reset
address  in  ADDR_WIDTH  beat address, sampled only on command acceptance
burstcount  in  BURST_WIDTH  beats in burst, sampled only on command acceptance
read  in  1  read command
write  in  1  write command / write beat
writedata  in  DATA_WIDTH  write beat data
byteenable  in  DATA_WIDTH/8  per-byte write enable
waitrequest  out  1  responder not accepting the current command/beat
readdata  out  DATA_WIDTH  read beat data
readdatavalid  out  1  readdata holds a valid beat
stall  in  1  forces waitrequest high while asserted (test backpressure)
busy  out  1  burst in progress (state != IDLE)
protocol_error  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; waitrequest=1; readdatavalid=0; readdata=0; busy=0; protocol_error=0. Pending reads are squashed. RAM contents are not cleared.
- waitrequest = stall OR reset OR (state==READ_BURST) OR (state==IDLE AND first cycle after reset release).
- Acceptance: a command or beat is accepted on the rising edge where (read|write)=1 and waitrequest=0.
- Address map: RAM index = (latched address + beat offset) mod 2^MEM_DEPTH_LOG2. Upper address bits are ignored. Bursts wrap silently past the top of the RAM.
- IDLE, write accepted:
  - Latch address and burstcount.
  - Beat 0 is written on the same edge, byte lanes gated by byteenable.
  - burstcount==1: stay IDLE. burstcount>1: go to WRITE_BURST with remaining = burstcount-1.
- WRITE_BURST:
  - waitrequest=stall. Each accepted write beat writes RAM[base+n] and decrements remaining. address and burstcount are ignored.
  - On the last beat, return to IDLE on the same edge.
  - Cycles with write=0 are idle gaps and are legal.
  - read=1 in this state sets protocol_error; the read is ignored.
- IDLE, read accepted:
  - Latch base address and count; go to READ_BURST.
  - The RAM is read once per cycle from the following cycle.
  - Beat n appears with readdatavalid=1 in cycle T0+READ_LATENCY+n, where T0 is the acceptance edge. Beats are back-to-back with no gaps; stall does not pause returning data.
- READ_BURST: waitrequest=1. Return to IDLE in the cycle after the last readdatavalid, so a new command can be accepted at T0+READ_LATENCY+burstcount at the earliest.
- Read-after-write coherence: a read accepted the cycle after a write beat returns the new data. The write port has priority; the RAM is write-first.
- burstcount==0 on an accepted command: protocol_error=1; no RAM access; state stays IDLE.
- read and write both asserted in IDLE: the write is serviced, the read is dropped, and protocol_error=1.
- readdata holds its last value when readdatavalid=0.
- busy = (state != IDLE), registered.

Decomposition:
- Package rush3d_avalon_pkg holds:
  - the state enum {IDLE, WRITE_BURST, READ_BURST};
  - the f2h width constants (ADDR 29, DATA 64, BURST 8);
  - MAX_READ_LATENCY=8.
- Sub-module byte_ram: single-clock simple dual-port RAM with per-byte write enables, write-first behaviour and a 1-cycle synchronous read.
- READ_LATENCY-1 extra valid/data pipeline stages live in the top module.

Test Plan:
- Write burst, address 0x10, burstcount 4, data 0x1111_1111_1111_1111 × n (n=1..4), byteenable 0xFF; then read burst at 0x10, count 4 -> readdatavalid in T0+2..T0+5 with data 0x1111..×1..×4 in order; protocol_error=0.
- Single write to 0x20 of 0xAAAA_AAAA_AAAA_AAAA, then a write of 0x5555_5555_5555_5555 with byteenable 0x0F; read 0x20 -> 0xAAAA_AAAA_5555_5555.
- Write burst of 3 at address 0xFFF (depth 4096), data 1,2,3; read 0x000 count 2 -> 2,3; read 0xFFF count 1 -> 1; address bit 12 is ignored, so a read at 0x1FFF returns 1.
- stall held high 5 cycles mid write burst of 8 -> waitrequest=1 for exactly those cycles, no beats lost or duplicated; full readback matches.
- Read with burstcount 0 -> protocol_error=1, no readdatavalid, busy stays 0; read and write together in IDLE -> write lands, read dropped.
- Reset asserted in the cycle after a read burst of 16 is accepted -> readdatavalid=0 immediately and stays 0; after release the first command is accepted no earlier than the second cycle; prior RAM contents are intact.
